// File: rtl/bezier_pkg.sv
`default_nettype none
// ============================================================================
// Package : bezier_pkg
// Brief   : Shared widths and build-FSM state encoding for the tone-curve LUT.
// Rev     : 1.0  initial release
// ============================================================================
package bezier_pkg;

    localparam int LUT_ENTRIES = 256;
    localparam int T_W         = 16;
    localparam int P_W         = 10;
    localparam int PIX_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage : bezier_pkg
`default_nettype wire

// File: rtl/bezier_lut_ram.sv
`default_nettype none
// ============================================================================
// Module : bezier_lut_ram
// Brief  : Tone LUT storage; one synchronous write port, three async reads.
// Rev    : 1.0  initial release
// ============================================================================
module bezier_lut_ram
    import bezier_pkg::*;
#(
    parameter int ADDR_W = $clog2(LUT_ENTRIES),
    parameter int DATA_W = PIX_W
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_r,
    input  logic [ADDR_W-1:0] i_raddr_g,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_r,
    output logic [DATA_W-1:0] o_rdata_g,
    output logic [DATA_W-1:0] o_rdata_b
);

    // Contents are meaningless until a build completes, so no reset.
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_r = r_mem[i_raddr_r];
    assign o_rdata_g = r_mem[i_raddr_g];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule : bezier_lut_ram
`default_nettype wire

// File: rtl/bezier_tone_lut.sv
`default_nettype none
// ============================================================================
// Module : bezier_tone_lut
// Brief  : Sweeps the external Bezier evaluator to fill a tone LUT, then maps
//          8-bit R/G/B video through it with a fixed 2-cycle latency.
// Rev    : 1.0  initial release
// ============================================================================
module bezier_tone_lut
    import bezier_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int BEZ_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [P_W-1:0]    P1_IN,
    input  logic [P_W-1:0]    P2_IN,
    output logic [P_W-1:0]    BZ_P1,
    output logic [P_W-1:0]    BZ_P2,
    output logic [T_W-1:0]    BZ_T,
    input  logic [PIX_W-1:0]  BZ_TT,
    output logic              BUSY,
    output logic              LUT_VALID,
    input  logic              PIX_DVAL,
    input  logic [ADDR_W-1:0] PIX_R,
    input  logic [ADDR_W-1:0] PIX_G,
    input  logic [ADDR_W-1:0] PIX_B,
    output logic              OUT_DVAL,
    output logic [PIX_W-1:0]  OUT_R,
    output logic [PIX_W-1:0]  OUT_G,
    output logic [PIX_W-1:0]  OUT_B
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_finish;
    logic               w_issue;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic               w_last_wr;

    logic [ADDR_W-1:0]  r_addr;
    logic [BEZ_LAT-1:0] r_dly_v;
    logic [ADDR_W-1:0]  r_dly_a [BEZ_LAT];
    logic               r_pending;
    logic               r_busy;
    logic               r_lut_valid;
    logic [P_W-1:0]     r_p1;
    logic [P_W-1:0]     r_p2;

    logic               r_s1_dval;
    logic               r_s1_map;
    logic [ADDR_W-1:0]  r_s1_r;
    logic [ADDR_W-1:0]  r_s1_g;
    logic [ADDR_W-1:0]  r_s1_b;
    logic               r_out_dval;
    logic [PIX_W-1:0]   r_out_r;
    logic [PIX_W-1:0]   r_out_g;
    logic [PIX_W-1:0]   r_out_b;
    logic [PIX_W-1:0]   w_lut_r;
    logic [PIX_W-1:0]   w_lut_g;
    logic [PIX_W-1:0]   w_lut_b;

    assign w_issue   = (r_state == ST_SWEEP);
    assign w_wr_en   = r_dly_v[BEZ_LAT-1];
    assign w_wr_addr = r_dly_a[BEZ_LAT-1];
    assign w_last_wr = w_wr_en && (w_wr_addr == '1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A START arriving on the final drain cycle joins the pending request.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_SWEEP;
                    w_load      = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (r_addr == '1) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_wr) begin
                    if (r_pending || START) begin
                        w_state_nxt = ST_SWEEP;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_finish    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_addr      <= '0;
            r_dly_v     <= '0;
            for (int i = 0; i < BEZ_LAT; i++) begin
                r_dly_a[i] <= '0;
            end
            r_pending   <= 1'b0;
            r_busy      <= 1'b0;
            r_lut_valid <= 1'b0;
            r_p1        <= '0;
            r_p2        <= '0;
        end else begin
            // Address parks at the top so BZ_T holds 0xFFFF after the sweep.
            if (w_load) begin
                r_addr <= '0;
            end else if (w_issue && (r_addr != '1)) begin
                r_addr <= r_addr + 1'b1;
            end

            r_dly_v[0] <= w_issue;
            r_dly_a[0] <= r_addr;
            for (int i = 1; i < BEZ_LAT; i++) begin
                r_dly_v[i] <= r_dly_v[i-1];
                r_dly_a[i] <= r_dly_a[i-1];
            end

            if (w_load) begin
                r_pending <= 1'b0;
            end else if (START && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (w_load) begin
                r_busy      <= 1'b1;
                r_lut_valid <= 1'b0;
                r_p1        <= P1_IN;
                r_p2        <= P2_IN;
            end else if (w_finish) begin
                r_busy      <= 1'b0;
                r_lut_valid <= 1'b1;
            end
        end
    end

    bezier_lut_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .CLK       (CLK),
        .i_we      (w_wr_en),
        .i_waddr   (w_wr_addr),
        .i_wdata   (BZ_TT),
        .i_raddr_r (r_s1_r),
        .i_raddr_g (r_s1_g),
        .i_raddr_b (r_s1_b),
        .o_rdata_r (w_lut_r),
        .o_rdata_g (w_lut_g),
        .o_rdata_b (w_lut_b)
    );

    // The snapshot taken with the pixel decides mapping for all three components.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_dval  <= 1'b0;
            r_s1_map   <= 1'b0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_out_dval <= 1'b0;
            r_out_r    <= '0;
            r_out_g    <= '0;
            r_out_b    <= '0;
        end else begin
            r_s1_dval  <= PIX_DVAL;
            r_s1_map   <= r_lut_valid;
            r_s1_r     <= PIX_R;
            r_s1_g     <= PIX_G;
            r_s1_b     <= PIX_B;
            r_out_dval <= r_s1_dval;
            if (r_s1_dval) begin
                r_out_r <= r_s1_map ? w_lut_r : r_s1_r;
                r_out_g <= r_s1_map ? w_lut_g : r_s1_g;
                r_out_b <= r_s1_map ? w_lut_b : r_s1_b;
            end
        end
    end

    assign BZ_P1     = r_p1;
    assign BZ_P2     = r_p2;
    assign BZ_T      = {r_addr, r_addr};
    assign BUSY      = r_busy;
    assign LUT_VALID = r_lut_valid;
    assign OUT_DVAL  = r_out_dval;
    assign OUT_R     = r_out_r;
    assign OUT_G     = r_out_g;
    assign OUT_B     = r_out_b;

endmodule : bezier_tone_lut
`default_nettype wire

// File: tb/tb_bezier_tone_lut.sv
`default_nettype none
// ============================================================================
// Module : tb_bezier_tone_lut
// Brief  : Self-checking bench; evaluator model plus behavioural reference.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bezier_tone_lut;

    localparam int LAT = 2;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic [9:0] P1_IN = '0;
    logic [9:0] P2_IN = '0;
    logic [9:0] BZ_P1;
    logic [9:0] BZ_P2;
    logic [15:0] BZ_T;
    logic [7:0] BZ_TT;
    logic       BUSY;
    logic       LUT_VALID;
    logic       PIX_DVAL = 1'b0;
    logic [7:0] PIX_R = '0;
    logic [7:0] PIX_G = '0;
    logic [7:0] PIX_B = '0;
    logic       OUT_DVAL;
    logic [7:0] OUT_R;
    logic [7:0] OUT_G;
    logic [7:0] OUT_B;

    always #5 CLK = ~CLK;

    bezier_tone_lut #(
        .ADDR_W  (8),
        .BEZ_LAT (LAT)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .P1_IN     (P1_IN),
        .P2_IN     (P2_IN),
        .BZ_P1     (BZ_P1),
        .BZ_P2     (BZ_P2),
        .BZ_T      (BZ_T),
        .BZ_TT     (BZ_TT),
        .BUSY      (BUSY),
        .LUT_VALID (LUT_VALID),
        .PIX_DVAL  (PIX_DVAL),
        .PIX_R     (PIX_R),
        .PIX_G     (PIX_G),
        .PIX_B     (PIX_B),
        .OUT_DVAL  (OUT_DVAL),
        .OUT_R     (OUT_R),
        .OUT_G     (OUT_G),
        .OUT_B     (OUT_B)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Cubic Bezier with end points 0 and 1023, t = T/65535, scaled to 8 bits.
    function automatic logic [7:0] golden(input int p1, input int p2, input int t);
        longint u  = 65535 - t;
        longint tt = t;
        longint d  = 64'd65535 * 64'd65535 * 64'd65535 * 64'd4;
        longint num;
        num = 3 * u * u * tt * p1 + 3 * u * tt * tt * p2 + tt * tt * tt * 1023;
        return 8'(num / d);
    endfunction

    // External evaluator: registered, LAT cycles from BZ_T to BZ_TT.
    logic [7:0] ev1 = '0;
    logic [7:0] ev2 = '0;
    always @(posedge CLK) begin
        ev1 <= golden(int'(BZ_P1), int'(BZ_P2), int'(BZ_T));
        ev2 <= ev1;
    end
    assign BZ_TT = ev2;

    // Reference model
    typedef struct {
        bit         dval;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    int          m_n = 0;
    bit          m_busy = 0;
    bit          m_valid = 0;
    bit          m_pending = 0;
    int          m_p1 = 0;
    int          m_p2 = 0;
    int          m_t0 = 0;
    int          m_end = 0;
    logic [15:0] m_t = '0;
    logic [7:0]  mlut [256];
    pix_t        q [$];
    bit          m_odval = 0;
    logic [7:0]  m_or = '0;
    logic [7:0]  m_og = '0;
    logic [7:0]  m_ob = '0;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_busy = 0; m_valid = 0; m_pending = 0;
            m_p1 = 0; m_p2 = 0; m_t = '0;
            q.delete();
            m_odval = 0; m_or = '0; m_og = '0; m_ob = '0;
        end else begin
            pix_t it;
            m_n++;
            it.dval = PIX_DVAL;
            it.r = m_valid ? mlut[PIX_R] : PIX_R;
            it.g = m_valid ? mlut[PIX_G] : PIX_G;
            it.b = m_valid ? mlut[PIX_B] : PIX_B;
            q.push_back(it);
            if (q.size() > 1) begin
                it = q.pop_front();
                m_odval = it.dval;
                if (it.dval) begin
                    m_or = it.r; m_og = it.g; m_ob = it.b;
                end
            end
            if (!m_busy) begin
                if (START) begin
                    m_busy = 1; m_valid = 0;
                    m_p1 = int'(P1_IN); m_p2 = int'(P2_IN);
                    m_t0 = m_n; m_end = m_n + 256 + LAT; m_t = '0;
                end
            end else begin
                if (m_n - m_t0 >= 1 && m_n - m_t0 <= 255) m_t = 16'((m_n - m_t0) * 257);
                if (m_n == m_end) begin
                    if (m_pending || START) begin
                        m_pending = 0;
                        m_p1 = int'(P1_IN); m_p2 = int'(P2_IN);
                        m_t0 = m_n; m_end = m_n + 256 + LAT; m_t = '0;
                    end else begin
                        m_busy = 0; m_valid = 1;
                        for (int a = 0; a < 256; a++) mlut[a] = golden(m_p1, m_p2, a * 257);
                    end
                end else if (START) begin
                    m_pending = 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy",      32'(BUSY),      32'(m_busy));
            chk("lut_valid", 32'(LUT_VALID), 32'(m_valid));
            chk("bz_t",      32'(BZ_T),      32'(m_t));
            chk("bz_p1",     32'(BZ_P1),     32'(m_p1));
            chk("bz_p2",     32'(BZ_P2),     32'(m_p2));
            chk("out_dval",  32'(OUT_DVAL),  32'(m_odval));
            chk("out_r",     32'(OUT_R),     32'(m_or));
            chk("out_g",     32'(OUT_G),     32'(m_og));
            chk("out_b",     32'(OUT_B),     32'(m_ob));
        end
    end

    int         pix_mode  = 0;
    logic [7:0] pix_const = 8'h40;

    task automatic drive_pix();
        case (pix_mode)
            0: begin
                PIX_DVAL = 1'b1; PIX_R = pix_const; PIX_G = pix_const; PIX_B = pix_const;
            end
            1: begin
                PIX_DVAL = ($urandom_range(0, 3) != 0);
                PIX_R = 8'($urandom); PIX_G = 8'($urandom); PIX_B = 8'($urandom);
            end
            default: begin
                PIX_DVAL = 1'b1;
                PIX_R = 8'($urandom); PIX_G = 8'($urandom); PIX_B = 8'($urandom);
            end
        endcase
    endtask

    // Starts a build and counts the cycles BUSY stays high.
    task automatic build(input int p1, input int p2, input int second_at,
                         input int p1b, input int p2b, output int n);
        P1_IN = 10'(p1); P2_IN = 10'(p2); START = 1'b1;
        drive_pix();
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (BUSY && n < 2000) begin
            n++;
            if (n == 1)   chk("bzt_first",  32'(BZ_T), 32'h0000);
            if (n == 2)   chk("bzt_second", 32'(BZ_T), 32'h0101);
            if (n == 256) chk("bzt_last",   32'(BZ_T), 32'hFFFF);
            START = (n == second_at);
            if (n == second_at) begin
                P1_IN = 10'(p1b); P2_IN = 10'(p2b);
            end
            drive_pix();
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        chk("gold_t0",       32'(golden(0, 1023, 0)),        32'd0);
        chk("gold_tmax",     32'(golden(0, 1023, 65535)),    32'd255);
        chk("gold_tmid",     32'(golden(0, 1023, 16'h8080)), 32'd128);
        chk("gold_512_tmid", 32'(golden(512, 512, 16'h8080)), 32'd128);

        repeat (3) @(negedge CLK);
        chk_en  = 1;
        RESET_N = 1'b1;

        // Bypass before any build
        pix_mode = 0; pix_const = 8'h40;
        drive_pix();
        repeat (3) @(negedge CLK);
        chk("bypass_r",     32'(OUT_R),     32'h40);
        chk("bypass_valid", 32'(LUT_VALID), 32'd0);
        chk("bypass_dval",  32'(OUT_DVAL),  32'd1);

        // Single build, linear-ish curve
        pix_mode = 1;
        build(0, 1023, 0, 0, 0, n);
        chk("busy_len_single", 32'(n), 32'd258);
        chk("valid_at_done",   32'(LUT_VALID), 32'd1);

        // Full LUT readback through the pixel path, with gaps
        for (int v = 0; v < 256; v++) begin
            PIX_DVAL = (v % 7 != 3);
            PIX_R = 8'(v); PIX_G = 8'(255 - v); PIX_B = 8'(v) ^ 8'h5A;
            @(negedge CLK);
        end
        PIX_DVAL = 1'b1; PIX_R = 8'h00; PIX_G = 8'h80; PIX_B = 8'hFF;
        @(negedge CLK);
        PIX_DVAL = 1'b0; PIX_R = 8'h11; PIX_G = 8'h22; PIX_B = 8'h33;
        @(negedge CLK);
        chk("map_r0",    32'(OUT_R),    32'd0);
        chk("map_g128",  32'(OUT_G),    32'd128);
        chk("map_b255",  32'(OUT_B),    32'd255);
        chk("map_dval",  32'(OUT_DVAL), 32'd1);
        @(negedge CLK);
        chk("gap_dval",  32'(OUT_DVAL), 32'd0);
        chk("gap_hold",  32'(OUT_G),    32'd128);

        // Second START mid-build collapses into one pending rebuild
        build(0, 1023, 100, 512, 512, n);
        chk("busy_len_pending", 32'(n), 32'd516);
        chk("pending_p1",       32'(BZ_P1), 32'd512);
        PIX_DVAL = 1'b1; PIX_R = 8'h80; PIX_G = 8'h00; PIX_B = 8'hFF;
        @(negedge CLK);
        PIX_DVAL = 1'b0;
        @(negedge CLK);
        chk("map512_r128", 32'(OUT_R), 32'd128);

        // Asynchronous reset in the middle of a sweep
        pix_mode = 0; pix_const = 8'h33;
        P1_IN = 10'd100; P2_IN = 10'd900; START = 1'b1;
        drive_pix();
        @(negedge CLK);
        START = 1'b0;
        k = 0;
        while (BZ_T !== 16'h8080 && k < 400) begin
            k++;
            @(negedge CLK);
        end
        chk("reach_addr128", 32'(BZ_T), 32'h8080);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_busy",  32'(BUSY),      32'd0);
        chk("rst_valid", 32'(LUT_VALID), 32'd0);
        chk("rst_bzt",   32'(BZ_T),      32'd0);
        chk("rst_bzp1",  32'(BZ_P1),     32'd0);
        chk("rst_out_r", 32'(OUT_R),     32'd0);
        chk("rst_dval",  32'(OUT_DVAL),  32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post_rst_bypass", 32'(OUT_G), 32'h33);

        // Continuous pixel stream across the end of a build
        pix_mode = 2;
        build(200, 300, 0, 0, 0, n);
        chk("busy_len_stream", 32'(n), 32'd258);
        repeat (10) begin
            drive_pix();
            @(negedge CLK);
        end

        // Randomised phase
        pix_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            START = ($urandom_range(0, 299) == 0);
            if (START || $urandom_range(0, 19) == 0) begin
                P1_IN = 10'($urandom_range(0, 1023));
                P2_IN = 10'($urandom_range(0, 1023));
            end
            drive_pix();
            @(negedge CLK);
        end
        START = 1'b0;
        k = 0;
        while (BUSY && k < 2000) begin
            k++;
            drive_pix();
            @(negedge CLK);
        end
        chk("final_idle", 32'(BUSY), 32'd0);
        repeat (4) @(negedge CLK);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bezier_tone_lut
`default_nettype wire
